// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared types and constants for the UART loader.
//   cmd_t   - command byte encodings accepted on the UART stream
//   state_t - loader FSM states (also exported on the debug port)
//   ACK/NAK - single-byte responses
//   lane_strobe() - one-hot byte-lane write strobe from the low address bits
package uart_loader_pkg;

  typedef enum logic [7:0] {
    CPU_RUN = 8'h01,
    CPU_RST = 8'h02,
    IRAM_WR = 8'h10,
    IRAM_RD = 8'h11,
    DRAM_WR = 8'h20,
    DRAM_RD = 8'h21
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    RD_SEND,
    RESP
  } state_t;

  localparam logic [7:0] ACK = 8'h4F;
  localparam logic [7:0] NAK = 8'hEE;

  function automatic logic [3:0] lane_strobe(input logic [1:0] a);
    return 4'b0001 << a;
  endfunction

endpackage

// File: rtl/uart_loader_if.sv
// uart_loader_if: byte streams between the UART blocks and the loader.
//   uart_rx_data / uart_rx_data_vld / uart_rx_data_rdy : bytes into the loader
//   uart_tx_data / uart_tx_data_vld / uart_tx_data_rdy : bytes out of the loader
// Modports: slave = loader side, master = UART / testbench side.
//
// Handshake: a byte moves on a rising clock edge where vld and rdy are both
// high. A producer that raises vld keeps vld high and data stable until that
// edge; rdy may change freely and never depends on vld.
interface uart_loader_if;
  logic [7:0] uart_rx_data;
  logic       uart_rx_data_vld;
  logic       uart_rx_data_rdy;
  logic [7:0] uart_tx_data;
  logic       uart_tx_data_vld;
  logic       uart_tx_data_rdy;

  modport slave (
    input  uart_rx_data, uart_rx_data_vld,
    output uart_rx_data_rdy,
    output uart_tx_data, uart_tx_data_vld,
    input  uart_tx_data_rdy
  );

  modport master (
    output uart_rx_data, uart_rx_data_vld,
    input  uart_rx_data_rdy,
    input  uart_tx_data, uart_tx_data_vld,
    output uart_tx_data_rdy
  );
endinterface

// File: rtl/uart_loader_tmo.sv
// uart_loader_tmo: inter-byte timeout counter.
//   clk_i, rst_n_i : clock, async active-low reset
//   clr_i          : restart the count (byte accepted or not waiting)
//   en_i           : count this cycle
//   expired_o      : TIMEOUT idle cycles have elapsed while enabled
module uart_loader_tmo #(
  parameter int unsigned TIMEOUT = 32'd1_000_000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [31:0] cnt_q;

  // Saturates at TIMEOUT so a stuck enable cannot wrap back to "fresh".
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q < TIMEOUT)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign expired_o = en_i && (cnt_q >= TIMEOUT);

endmodule

// File: rtl/uart_loader.sv
// uart_loader: UART command engine that loads / reads back IRAM and DRAM and
// controls the CPU reset.
//   clk_i, rst_n_i         : clock, async active-low reset
//   uart (slave modport)   : rx byte stream in, tx response stream out
//   ram_rd_data_i          : RAM readback byte, valid one cycle after address
//   cpu_rst_n_o            : CPU reset, low holds the CPU in reset
//   iram/dram_rd/wr_sel_o  : RAM port selects
//   ram_rw_addr_o          : byte address
//   ram_wr_byte_en_o       : one-hot byte-lane strobe, one cycle per byte
//   ram_wr_data_o          : write byte (replicated to lanes outside)
//   dbg_state_o            : current FSM state
// Frame: CMD, ADDR (XLEN/8 bytes, LSB first), LEN (XLEN/8 bytes, LSB first),
// payload. CPU_RUN / CPU_RST carry no address or length.
// Build option UART_LOADER_CHKSUM_EN: writes expect a trailing 8-bit sum of
// every frame byte (mismatch answers NAK, written data stays), reads append
// the 8-bit sum of the returned payload.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 32'd1_000_000
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  uart_loader_if.slave    uart,
  input  logic [7:0]      ram_rd_data_i,
  output logic            cpu_rst_n_o,
  output logic            iram_rd_sel_o,
  output logic            iram_wr_sel_o,
  output logic            dram_rd_sel_o,
  output logic            dram_wr_sel_o,
  output logic [XLEN-1:0] ram_rw_addr_o,
  output logic [3:0]      ram_wr_byte_en_o,
  output logic [7:0]      ram_wr_data_o,
  output state_t          dbg_state_o
);

  localparam int unsigned NB = XLEN / 8;
  localparam logic [XLEN-1:0] LEN_ONE = {{(XLEN-1){1'b0}}, 1'b1};

  state_t          state_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] len_q;
  logic [7:0]      bcnt_q;
  logic            is_wr_q;
  logic            is_dram_q;
  logic            rx_en_q;
  logic [7:0]      tx_data_q;
  logic            tx_vld_q;
  logic            cpu_rst_n_q;
  logic            iram_rd_sel_q;
  logic            iram_wr_sel_q;
  logic            dram_rd_sel_q;
  logic            dram_wr_sel_q;
  logic [3:0]      byte_en_q;
  logic [7:0]      wr_data_q;
`ifdef UART_LOADER_CHKSUM_EN
  logic [7:0]      chk_q;
  logic            chk_phase_q;   // payload done, sum byte is next
`endif

  logic            rx_rdy;
  logic            rx_fire;
  logic            tx_fire;
  logic            tmo_en;
  logic            tmo_clr;
  logic            tmo_expired;
  logic            hdr_last;
  logic [7:0]      rx_byte;
  logic [XLEN+7:0] addr_cat;
  logic [XLEN+7:0] len_cat;
  logic [XLEN-1:0] addr_shift_d;
  logic [XLEN-1:0] len_shift_d;
  logic [XLEN-1:0] addr_inc_d;
  logic [XLEN-1:0] len_dec_d;

  assign rx_byte = uart.uart_rx_data;

  // rx_en_q keeps ready low while in reset even though state_q reads IDLE.
  // In WR_DATA ready drops during the strobe cycle: one byte per two cycles.
  assign rx_rdy = rx_en_q &&
                  ((state_q == IDLE) || (state_q == ADDR) || (state_q == LEN) ||
                   ((state_q == WR_DATA) && (byte_en_q == 4'b0000)));
  assign rx_fire = uart.uart_rx_data_vld && rx_rdy;
  assign tx_fire = tx_vld_q && uart.uart_tx_data_rdy;

  // Header fields arrive LSB first: each new byte enters at the top.
  assign addr_cat     = {rx_byte, addr_q};
  assign len_cat      = {rx_byte, len_q};
  assign addr_shift_d = addr_cat[XLEN+7:8];
  assign len_shift_d  = len_cat[XLEN+7:8];
  assign addr_inc_d   = addr_q + LEN_ONE;
  assign len_dec_d    = len_q - LEN_ONE;
  assign hdr_last     = (bcnt_q == 8'(NB - 1));

  assign tmo_en  = (state_q == ADDR) || (state_q == LEN) || (state_q == WR_DATA);
  assign tmo_clr = rx_fire || !tmo_en;

  uart_loader_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_expired)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      bcnt_q        <= '0;
      is_wr_q       <= 1'b0;
      is_dram_q     <= 1'b0;
      rx_en_q       <= 1'b0;
      tx_data_q     <= '0;
      tx_vld_q      <= 1'b0;
      cpu_rst_n_q   <= 1'b0;
      iram_rd_sel_q <= 1'b0;
      iram_wr_sel_q <= 1'b0;
      dram_rd_sel_q <= 1'b0;
      dram_wr_sel_q <= 1'b0;
      byte_en_q     <= '0;
      wr_data_q     <= '0;
`ifdef UART_LOADER_CHKSUM_EN
      chk_q         <= '0;
      chk_phase_q   <= 1'b0;
`endif
    end else begin
      rx_en_q   <= 1'b1;
      byte_en_q <= 4'b0000;   // strobe lasts exactly one cycle
      if (tmo_expired) begin
        // Abandon the command silently.
        state_q       <= IDLE;
        iram_wr_sel_q <= 1'b0;
        dram_wr_sel_q <= 1'b0;
        iram_rd_sel_q <= 1'b0;
        dram_rd_sel_q <= 1'b0;
`ifdef UART_LOADER_CHKSUM_EN
        chk_phase_q   <= 1'b0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            if (rx_fire) begin
              case (rx_byte)
                CPU_RUN: begin
                  cpu_rst_n_q <= 1'b1;
                  tx_data_q   <= ACK;
                  tx_vld_q    <= 1'b1;
                  state_q     <= RESP;
                end
                CPU_RST: begin
                  cpu_rst_n_q <= 1'b0;
                  tx_data_q   <= ACK;
                  tx_vld_q    <= 1'b1;
                  state_q     <= RESP;
                end
                IRAM_WR, IRAM_RD, DRAM_WR, DRAM_RD: begin
                  is_wr_q   <= ~rx_byte[0];
                  is_dram_q <= rx_byte[5];
                  bcnt_q    <= '0;
                  state_q   <= ADDR;
`ifdef UART_LOADER_CHKSUM_EN
                  chk_q     <= rx_byte;
`endif
                end
                default: ;  // unknown command bytes are dropped
              endcase
            end
          end

          ADDR: begin
            if (rx_fire) begin
              addr_q <= addr_shift_d;
              bcnt_q <= hdr_last ? 8'd0 : bcnt_q + 8'd1;
              if (hdr_last) state_q <= LEN;
`ifdef UART_LOADER_CHKSUM_EN
              chk_q  <= chk_q + rx_byte;
`endif
            end
          end

          LEN: begin
            if (rx_fire) begin
              len_q  <= len_shift_d;
              bcnt_q <= hdr_last ? 8'd0 : bcnt_q + 8'd1;
`ifdef UART_LOADER_CHKSUM_EN
              chk_q  <= chk_q + rx_byte;
`endif
              if (hdr_last) begin
                if (cpu_rst_n_q) begin
                  // RAM is only reachable while the CPU is held in reset.
                  tx_data_q <= NAK;
                  tx_vld_q  <= 1'b1;
                  state_q   <= RESP;
                end else if (is_wr_q) begin
`ifdef UART_LOADER_CHKSUM_EN
                  // Even an empty write carries its sum byte.
                  iram_wr_sel_q <= ~is_dram_q;
                  dram_wr_sel_q <= is_dram_q;
                  chk_phase_q   <= (len_shift_d == '0);
                  state_q       <= WR_DATA;
`else
                  if (len_shift_d == '0) begin
                    tx_data_q <= ACK;
                    tx_vld_q  <= 1'b1;
                    state_q   <= RESP;
                  end else begin
                    iram_wr_sel_q <= ~is_dram_q;
                    dram_wr_sel_q <= is_dram_q;
                    state_q       <= WR_DATA;
                  end
`endif
                end else if (len_shift_d == '0) begin
                  state_q <= IDLE;
                end else begin
                  iram_rd_sel_q <= ~is_dram_q;
                  dram_rd_sel_q <= is_dram_q;
                  state_q       <= RD_ADDR;
`ifdef UART_LOADER_CHKSUM_EN
                  chk_q         <= '0;
`endif
                end
              end
            end
          end

          WR_DATA: begin
            if (byte_en_q != 4'b0000) begin
              // Strobe cycle: advance to the next byte.
              addr_q <= addr_inc_d;
              len_q  <= len_dec_d;
              if (len_q == LEN_ONE) begin
`ifdef UART_LOADER_CHKSUM_EN
                chk_phase_q   <= 1'b1;
`else
                iram_wr_sel_q <= 1'b0;
                dram_wr_sel_q <= 1'b0;
                tx_data_q     <= ACK;
                tx_vld_q      <= 1'b1;
                state_q       <= RESP;
`endif
              end
            end else if (rx_fire) begin
`ifdef UART_LOADER_CHKSUM_EN
              if (chk_phase_q) begin
                chk_phase_q   <= 1'b0;
                iram_wr_sel_q <= 1'b0;
                dram_wr_sel_q <= 1'b0;
                tx_data_q     <= (chk_q == rx_byte) ? ACK : NAK;
                tx_vld_q      <= 1'b1;
                state_q       <= RESP;
              end else begin
                wr_data_q <= rx_byte;
                byte_en_q <= lane_strobe(addr_q[1:0]);
                chk_q     <= chk_q + rx_byte;
              end
`else
              wr_data_q <= rx_byte;
              byte_en_q <= lane_strobe(addr_q[1:0]);
`endif
            end
          end

          RD_ADDR: begin
            state_q <= RD_WAIT;
          end

          RD_WAIT: begin
            tx_data_q <= ram_rd_data_i;
            tx_vld_q  <= 1'b1;
            state_q   <= RD_SEND;
`ifdef UART_LOADER_CHKSUM_EN
            chk_q     <= chk_q + ram_rd_data_i;
`endif
          end

          RD_SEND: begin
            if (tx_fire) begin
              tx_vld_q <= 1'b0;
`ifdef UART_LOADER_CHKSUM_EN
              if (chk_phase_q) begin
                chk_phase_q <= 1'b0;
                state_q     <= IDLE;
              end else begin
                addr_q <= addr_inc_d;
                len_q  <= len_dec_d;
                if (len_q == LEN_ONE) begin
                  // Sum byte follows the last data byte from this state.
                  iram_rd_sel_q <= 1'b0;
                  dram_rd_sel_q <= 1'b0;
                  chk_phase_q   <= 1'b1;
                  tx_data_q     <= chk_q;
                  tx_vld_q      <= 1'b1;
                end else begin
                  state_q <= RD_ADDR;
                end
              end
`else
              addr_q <= addr_inc_d;
              len_q  <= len_dec_d;
              if (len_q == LEN_ONE) begin
                iram_rd_sel_q <= 1'b0;
                dram_rd_sel_q <= 1'b0;
                state_q       <= IDLE;
              end else begin
                state_q <= RD_ADDR;
              end
`endif
            end
          end

          RESP: begin
            if (tx_fire) begin
              tx_vld_q <= 1'b0;
              state_q  <= IDLE;
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign uart.uart_rx_data_rdy = rx_rdy;
  assign uart.uart_tx_data     = tx_data_q;
  assign uart.uart_tx_data_vld = tx_vld_q;
  assign cpu_rst_n_o           = cpu_rst_n_q;
  assign iram_rd_sel_o         = iram_rd_sel_q;
  assign iram_wr_sel_o         = iram_wr_sel_q;
  assign dram_rd_sel_o         = dram_rd_sel_q;
  assign dram_wr_sel_o         = dram_wr_sel_q;
  assign ram_rw_addr_o         = addr_q;
  assign ram_wr_byte_en_o      = byte_en_q;
  assign ram_wr_data_o         = wr_data_q;
  assign dbg_state_o           = state_q;

endmodule
